// File: rtl/gearbox_param.sv
// Width-converting gearbox: IN_UNITS-unit writes in, OUT_UNITS-unit reads out, via a DEPTH-unit circular buffer.
// Latency: one edge from shift_out to data_out/valid_out; two edges from a write to the earliest output carrying it.
// Backpressure: full (combinational from registered level) blocks writes; a write while full is dropped and sets overflow_err.
module gearbox_param #(
    parameter int UNIT_W    = 4,
    parameter int IN_UNITS  = 4,
    parameter int OUT_UNITS = 5,
    parameter int DEPTH     = 32
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          shift_in,
    input  logic [IN_UNITS*UNIT_W-1:0]    data_in,
    output logic                          full,
    input  logic                          shift_out,
    input  logic                          flush,
    output logic [OUT_UNITS*UNIT_W-1:0]   data_out,
    output logic                          valid_out,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Constants pre-sized to the level width so every compare/add is width-exact.
    localparam logic [LW-1:0] IN_L    = LW'(IN_UNITS);
    localparam logic [LW-1:0] OUT_L   = LW'(OUT_UNITS);
    localparam logic [LW-1:0] FULL_TH = LW'(DEPTH - IN_UNITS);

    // Unit storage; contents are don't-care after reset, so no reset on the array.
    logic [UNIT_W-1:0] mem [DEPTH];

    logic [PW-1:0]                 wr_ptr;
    logic [PW-1:0]                 rd_ptr;
    logic                          wr_acc;
    logic                          rd_norm;
    logic                          rd_flush;
    logic [LW-1:0]                 units_rd;
    logic [OUT_UNITS*UNIT_W-1:0]   rd_word;

    // A write is only accepted if a whole input word fits, judged on the registered level.
    assign full = (level > FULL_TH);

    // Read/write decisions all use start-of-cycle level, so same-cycle writes are never read.
    always_comb begin
        wr_acc   = shift_in && !full;
        rd_norm  = shift_out && (level >= OUT_L);
        rd_flush = shift_out && flush && (level != '0) && (level < OUT_L);
        units_rd = '0;
        if (rd_norm) begin
            units_rd = OUT_L;
        end else if (rd_flush) begin
            units_rd = level;
        end
    end

    // Gather the next output word; on a flush the units beyond the current level read as zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < OUT_UNITS; k++) begin
            if (rd_norm || (LW'(k) < level)) begin
                rd_word[k*UNIT_W +: UNIT_W] = mem[rd_ptr + PW'(k)];
            end
        end
    end

    // Scatter an accepted input word into consecutive buffer slots starting at wr_ptr.
    always_ff @(posedge clk) begin
        if (!res && wr_acc) begin
            for (int k = 0; k < IN_UNITS; k++) begin
                mem[wr_ptr + PW'(k)] <= data_in[k*UNIT_W +: UNIT_W];
            end
        end
    end

    // Pointers, occupancy, registered outputs and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            data_out     <= '0;
            valid_out    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(IN_UNITS);
            end
            if (rd_norm || rd_flush) begin
                rd_ptr   <= rd_ptr + units_rd[PW-1:0];
                data_out <= rd_word;
            end
            valid_out <= rd_norm || rd_flush;
            level     <= level + (wr_acc ? IN_L : '0) - units_rd;
            if (shift_in && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/gearbox_param.md
# gearbox_param

Single-clock, parametrised width-conversion gearbox. It accepts IN_UNITS units of UNIT_W bits per write and emits OUT_UNITS units per read, through a circular unit buffer of DEPTH entries. It sits between a fixed-width producer and a differently sized consumer in the datapath. Compared with the fixed 16→20-bit gearbox it adds:
- arbitrary unit and width ratios
- an exact occupancy count
- a partial-word flush
- a sticky overflow flag

## Interface
Parameters:
- UNIT_W, 4: bits per unit.
- IN_UNITS, 4: units per input word; input width is IN_UNITS*UNIT_W.
- OUT_UNITS, 5: units per output word; output width is OUT_UNITS*UNIT_W.
- DEPTH, 32: buffer size in units. Must be a power of two and ≥ IN_UNITS+OUT_UNITS.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- res  in  1  reset: one clock, synchronous, active-high.
- shift_in  in  1  write request.
- data_in  in  IN_UNITS*UNIT_W  input word; unit k occupies bits [k*UNIT_W +: UNIT_W].
- full  out  1  combinational: level > DEPTH-IN_UNITS.
- shift_out  in  1  read request.
- flush  in  1  qualifies shift_out to allow emitting a partial word.
- data_out  out  OUT_UNITS*UNIT_W  registered output word.
- valid_out  out  1  registered; high for one cycle per emitted word.
- level  out  $clog2(DEPTH)+1  registered occupancy in units.
- overflow_err  out  1  sticky; set when a write is dropped.

## Operation
Internal state:
- Buffer of DEPTH×UNIT_W.
- wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- level, of width $clog2(DEPTH)+1.

Writes:
- A write is accepted when shift_in && !full.
- data_in unit k is stored at buffer[(wr_ptr+k) mod DEPTH].
- wr_ptr advances by IN_UNITS.
- If shift_in && full, the write is dropped and overflow_err is set to 1. overflow_err stays set until res.

Reads:
- A normal read happens when shift_out && level ≥ OUT_UNITS.
- data_out unit k is loaded from buffer[(rd_ptr+k) mod DEPTH].
- rd_ptr advances by OUT_UNITS and valid_out is driven to 1.

Flush reads:
- A flush read happens when shift_out && flush && 0 < level < OUT_UNITS.
- The low `level` units of data_out are loaded from the buffer in order. The remaining upper units are loaded with zero.
- rd_ptr advances by level, valid_out is driven to 1, and level consumed becomes the units read.
- If flush is asserted with level ≥ OUT_UNITS, a normal full-word read occurs.

No read:
- Applies when shift_out is low, or shift_out is high with level 0, or shift_out is high with level < OUT_UNITS and no flush.
- valid_out is driven to 0 and data_out holds its previous value.

Occupancy and concurrency:
- level_next = level + (write accepted ? IN_UNITS : 0) − (units read).
- All read and flush decisions use the level at the start of the cycle. A unit written in the same cycle is never read in that cycle.
- A simultaneous write and read is always legal. full is computed from the registered level only, and the buffer has no read/write address conflict because the read region and the free region are disjoint.

Reset (res=1 at a rising edge), including mid-stream:
- wr_ptr=0, rd_ptr=0, level=0.
- valid_out=0, data_out=0, overflow_err=0.
- full therefore reads 0.
- Buffer contents are don't-care.
- Any request present in the reset cycle is ignored.

## Timing
- Write at edge n: level reflects it after edge n, so the earliest read decision is in cycle n+1 and data_out/valid_out update at edge n+1 to n+2. Total write-to-output latency is 2 edges.
- Read latency: shift_out sampled at edge n gives data_out/valid_out valid after edge n, for one cycle.
- Sustained rate is one write and one read per cycle. Throughput is bounded by min(IN_UNITS, OUT_UNITS) units per cycle, with full/level providing backpressure.
- Pointer and level arithmetic is unsigned.
  - Pointers wrap silently modulo DEPTH.
  - level never exceeds DEPTH and never goes below 0; both are guaranteed by the acceptance rules.

## Test plan
Defaults: UNIT_W=4, IN_UNITS=4, OUT_UNITS=5, DEPTH=32.
- **Basic conversion.** Reset, write 0x4321 then 0x8765, then shift_out → data_out=0x54321 with valid_out=1 for one cycle, and level=3. A second shift_out → valid_out=0 and data_out holds.
- **Full and overflow.** Write 8 consecutive words → level=32 and full=1; full is 1 from level 29 onward. Then shift_in with 0xFFFF → dropped, level stays 32, overflow_err=1 and stays 1. A following read of 5 units → level=27, full=0.
- **Simultaneous write and read.** At level 5, assert shift_in and shift_out in the same cycle → level=4 and the emitted word is the 5 oldest units.
- **Flush.** From reset, write 0xABCD (level=4), then shift_out with flush → data_out=0x0ABCD, valid_out=1, level=0. Repeat shift_out with flush at level 0 → valid_out=0.
- **Wrap-around stream.** Write 40 words of an incrementing nibble pattern and read continuously → the concatenated output nibbles equal the input sequence exactly across multiple pointer wraps; overflow_err stays 0.
- **Reset mid-operation.** At level 12, with shift_in and shift_out high, assert res for one cycle → next cycle valid_out=0, data_out=0, level=0, full=0, overflow_err=0. Then write 0x1111, 0x2222 and read → data_out=0x21111.
